// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage owning the PC, one outstanding SRAM fetch, one entry handed to decode
// Ports: clk/rst; flush/new_pc exception redirect; stall[2] decode stall; br_e/br_addr branch redirect;
//        inst_sram_* fetch port; ic_to_id_bus {excepttype, ic_ce, ic_pc} and ic_inst toward decode.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic [5:0]  stall,
  input  logic        br_e,
  input  logic [31:0] br_addr,
  output logic [64:0] ic_to_id_bus,
  output logic [31:0] ic_inst,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, CANCEL, HOLD} state_t;
  state_t state, state_nxt;
  logic [31:0] pc, inst_q, target;
  logic exc_q, stop, redir, aligned, hold;
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[1:0]};
  assign stop = stall[2];
  // a branch seen while decode is stalled is dropped; decode re-asserts it later
  assign redir = flush | (br_e & ~stop);
  assign target = flush ? new_pc : br_addr;
  assign aligned = pc[1:0] == 2'b00;
  assign hold = state == HOLD;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     state_nxt = !aligned ? (redir ? REQ : HOLD)
                         : inst_sram_addr_ok ? (redir ? CANCEL : WAIT) : REQ;
      WAIT:    state_nxt = inst_sram_data_ok ? (redir ? REQ : HOLD) : (redir ? CANCEL : WAIT);
      CANCEL:  state_nxt = inst_sram_data_ok ? REQ : CANCEL;
      HOLD:    state_nxt = (redir || !stop) ? REQ : HOLD;
      default: state_nxt = IDLE;
    endcase
  end
  // entry pc is the PC itself: the PC never moves while an entry is held
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      inst_q <= '0;
      exc_q <= 1'b0;
    end else begin
      pc <= redir ? target : (hold && !stop) ? pc + 32'd4 : pc;
      if (state == REQ && !aligned && !redir) begin
        inst_q <= '0;
        exc_q <= 1'b1;
      end else if (state == WAIT && inst_sram_data_ok && !redir) begin
        inst_q <= inst_sram_rdata;
        exc_q <= 1'b0;
      end
    end
  always_comb begin
    inst_sram_req = state == REQ && aligned;
    inst_sram_addr = state == IDLE ? '0 : pc;
    ic_to_id_bus = hold ? {15'b0, exc_q, 16'b0, 1'b1, pc} : '0;
    ic_inst = hold ? inst_q : '0;
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed checks of if_fetch fetch, stall, redirect, misalignment and reset behaviour
module tb_if_fetch;
  logic        clk = 0, rst = 1, flush = 0, br_e = 0;
  logic [31:0] new_pc = 0, br_addr = 0;
  logic [5:0]  stall = 0;
  logic [64:0] ic_to_id_bus;
  logic [31:0] ic_inst, inst_sram_addr, inst_sram_rdata = 0;
  logic        inst_sram_req, inst_sram_addr_ok = 0, inst_sram_data_ok = 0;
  int errs = 0, checks = 0;
  if_fetch dut (
    .clk(clk), .rst(rst), .flush(flush), .new_pc(new_pc), .stall(stall),
    .br_e(br_e), .br_addr(br_addr), .ic_to_id_bus(ic_to_id_bus), .ic_inst(ic_inst),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [64:0] bus(input logic [31:0] exc, input logic [31:0] p);
    return {exc, 1'b1, p};
  endfunction
  initial begin
    repeat (2) step();
    chk("rst_req", inst_sram_req, 0);
    chk("rst_addr", inst_sram_addr, 0);
    chk("rst_bus", ic_to_id_bus, 0);
    chk("rst_inst", ic_inst, 0);
    rst = 0;
    chk("idle_req", inst_sram_req, 0);
    step();
    chk("req0", inst_sram_req, 1);
    chk("req0_addr", inst_sram_addr, 32'hBFC0_0000);
    inst_sram_addr_ok = 1;
    step();
    chk("wait_req", inst_sram_req, 0);
    chk("wait_ce", ic_to_id_bus[32], 0);
    inst_sram_addr_ok = 0; inst_sram_data_ok = 1; inst_sram_rdata = 32'h2408_0001;
    step();
    chk("hold_bus", ic_to_id_bus, bus(0, 32'hBFC0_0000));
    chk("hold_inst", ic_inst, 32'h2408_0001);
    inst_sram_data_ok = 0; stall = 6'b000100;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_bus", ic_to_id_bus, bus(0, 32'hBFC0_0000));
      chk("stall_inst", ic_inst, 32'h2408_0001);
      chk("stall_req", inst_sram_req, 0);
    end
    stall = 0;
    step();
    chk("req1", inst_sram_req, 1);
    chk("req1_addr", inst_sram_addr, 32'hBFC0_0004);
    chk("req1_ce", ic_to_id_bus[32], 0);
    inst_sram_addr_ok = 1;
    step();
    inst_sram_addr_ok = 0; br_e = 1; br_addr = 32'hBFC0_0100;
    step();
    br_e = 0;
    chk("cancel_req", inst_sram_req, 0);
    chk("cancel_ce", ic_to_id_bus[32], 0);
    step();
    chk("cancel2_req", inst_sram_req, 0);
    inst_sram_data_ok = 1; inst_sram_rdata = 32'hDEAD_BEEF;
    step();
    inst_sram_data_ok = 0;
    chk("br_req", inst_sram_req, 1);
    chk("br_addr", inst_sram_addr, 32'hBFC0_0100);
    chk("drop_inst", ic_inst, 0);
    chk("drop_bus", ic_to_id_bus, 0);
    inst_sram_addr_ok = 1;
    step();
    inst_sram_addr_ok = 0; inst_sram_data_ok = 1; inst_sram_rdata = 32'h3C1D_0001;
    step();
    inst_sram_data_ok = 0;
    chk("br_hold_bus", ic_to_id_bus, bus(0, 32'hBFC0_0100));
    chk("br_hold_inst", ic_inst, 32'h3C1D_0001);
    stall = 6'b000100; flush = 1; new_pc = 32'hBFC0_0380; br_e = 1; br_addr = 32'hBFC0_0200;
    step();
    flush = 0; br_e = 0; stall = 0;
    chk("flush_ce", ic_to_id_bus[32], 0);
    chk("flush_req", inst_sram_req, 1);
    chk("flush_addr", inst_sram_addr, 32'hBFC0_0380);
    br_e = 1; br_addr = 32'h8000_0002;
    step();
    br_e = 0;
    chk("mis_req", inst_sram_req, 0);
    step();
    chk("mis_bus", ic_to_id_bus, bus(32'h0001_0000, 32'h8000_0002));
    chk("mis_inst", ic_inst, 0);
    step();
    chk("mis_next_req", inst_sram_req, 0);
    chk("mis_next_ce", ic_to_id_bus[32], 0);
    br_e = 1; br_addr = 32'hBFC0_0010;
    step();
    br_e = 0;
    chk("realign_req", inst_sram_req, 1);
    chk("realign_addr", inst_sram_addr, 32'hBFC0_0010);
    inst_sram_addr_ok = 1;
    step();
    inst_sram_addr_ok = 0; inst_sram_data_ok = 1; inst_sram_rdata = 32'h1111_1111;
    br_e = 1; br_addr = 32'hBFC0_0020;
    step();
    inst_sram_data_ok = 0; br_e = 0;
    chk("wdrop_ce", ic_to_id_bus[32], 0);
    chk("wdrop_inst", ic_inst, 0);
    chk("wdrop_addr", inst_sram_addr, 32'hBFC0_0020);
    inst_sram_addr_ok = 1;
    step();
    inst_sram_addr_ok = 0;
    chk("w2_req", inst_sram_req, 0);
    rst = 1;
    #1;
    chk("arst_req", inst_sram_req, 0);
    chk("arst_addr", inst_sram_addr, 0);
    chk("arst_bus", ic_to_id_bus, 0);
    chk("arst_inst", ic_inst, 0);
    step();
    rst = 0;
    chk("post_idle_req", inst_sram_req, 0);
    step();
    chk("post_req", inst_sram_req, 1);
    chk("post_addr", inst_sram_addr, 32'hBFC0_0000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
